word_ram_arbiter: RTL and testbench

- Shares one SB_SPRAM256KA (16K x 16) between the spi_in write stream and up to READERS output engines (icnd2110_out / ws2812_out) that fetch pixel words.
- Sits between spi_in and the output engines. It replaces the per-engine word storage with one frame RAM.
- Writes are posted through a 2-entry FIFO and have priority. Readers are served round-robin with a starvation guard.

---
 rtl/word_ram_arbiter_pkg.sv | 14 +
 rtl/word_ram_arbiter_rr.sv | 46 ++++
 rtl/word_ram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_word_ram_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_ram_arbiter_pkg.sv
// Shared definitions for the frame-RAM arbiter: word/address widths and
// the per-cycle slot encoding.
package word_ram_pkg;

  localparam int WORD_WIDTH     = 16;
  localparam int RAM_ADDR_WIDTH = 14;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_WRITE = 2'd1,
    SLOT_READ  = 2'd2
  } slot_t;

endpackage

// File: rtl/word_ram_arbiter_rr.sv
// Round-robin requester selection. The pointer remembers the last winner;
// the search starts one past it so every requester is eventually served.
module rr_arbiter #(
  parameter  int READERS = 4,
  localparam int IDX_W   = (READERS > 1) ? $clog2(READERS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [READERS-1:0] req,
  input  logic               advance,
  output logic [READERS-1:0] grant,
  output logic [IDX_W-1:0]   grant_index
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cand_idx;
  logic             found;
  int               cand;

  // First requester after the pointer, wrapping; pointer follows the winner
  always_comb begin
    grant       = '0;
    grant_index = '0;
    found       = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= READERS; k++) begin
      cand     = (int'(ptr_q) + k) % READERS;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant_index     = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
    ptr_d = (advance && found) ? grant_index : ptr_q;
  end

  // Pointer starts at the last reader so reader 0 wins first after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IDX_W'(READERS - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/word_ram_arbiter.sv
// One SPRAM shared between the posted spi_in write stream (2-entry FIFO,
// priority) and READERS pixel fetch engines (round-robin, with a guard
// that forces a read slot after STARVE_LIMIT back-to-back writes).
module word_ram_arbiter
  import word_ram_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = 13,
  parameter int READERS           = 4,
  parameter int STARVE_LIMIT      = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [WORD_WIDTH-1:0]                      wr_data,
  input  logic [ADDRESS_BUS_WIDTH:0]                 wr_address,
  input  logic                                       wr_strobe,
  output logic                                       wr_overflow,
  input  logic [READERS-1:0]                         rd_req,
  input  logic [READERS*(ADDRESS_BUS_WIDTH+1)-1:0]   rd_address,
  output logic [READERS-1:0]                         rd_ack,
  output logic [READERS-1:0]                         rd_valid,
  output logic [WORD_WIDTH-1:0]                      rd_data,
  output logic [RAM_ADDR_WIDTH-1:0]                  ram_address,
  output logic [WORD_WIDTH-1:0]                      ram_data_in,
  output logic                                       ram_wren,
  output logic                                       ram_cs,
  input  logic [WORD_WIDTH-1:0]                      ram_data_out
);

  localparam int AW    = ADDRESS_BUS_WIDTH + 1;
  localparam int IDX_W = (READERS > 1) ? $clog2(READERS) : 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  slot_t                     slot;
  logic                      any_req, starved, push, pop;
  logic [READERS-1:0]        grant;
  logic [IDX_W-1:0]          grant_index;
  logic [RAM_ADDR_WIDTH-1:0] rd_addr_arr [READERS];

  logic [RAM_ADDR_WIDTH-1:0] fifo_addr_q [2];
  logic [RAM_ADDR_WIDTH-1:0] fifo_addr_d [2];
  logic [WORD_WIDTH-1:0]     fifo_data_q [2];
  logic [WORD_WIDTH-1:0]     fifo_data_d [2];
  logic [1:0]                cnt_q, cnt_d;
  logic                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SC_W-1:0]           starve_q, starve_d;
  logic                      overflow_q, overflow_d;

  logic                      ram_cs_q, ram_cs_d, ram_wren_q, ram_wren_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [WORD_WIDTH-1:0]     ram_data_in_q, ram_data_in_d;
  logic [READERS-1:0]        rd_ack_q, rd_ack_d;
  logic                      vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
  logic [IDX_W-1:0]          idx_p0_q, idx_p0_d, idx_p1_q, idx_p1_d;
  logic [READERS-1:0]        rd_valid_q, rd_valid_d;
  logic [WORD_WIDTH-1:0]     rd_data_q, rd_data_d;

  // Unpack reader addresses, keeping only the bits the RAM decodes
  for (genvar g = 0; g < READERS; g++) begin : g_addr
    assign rd_addr_arr[g] = rd_address[g*AW +: RAM_ADDR_WIDTH];
  end

  rr_arbiter #(.READERS(READERS)) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (rd_req),
    .advance    (slot == SLOT_READ),
    .grant      (grant),
    .grant_index(grant_index)
  );

  // Slot decision: queued writes win unless a pending reader is starved
  always_comb begin
    any_req = |rd_req;
    starved = (starve_q == SC_W'(STARVE_LIMIT)) && any_req;
    slot    = SLOT_IDLE;
    if ((cnt_q != 2'd0) && !starved) slot = SLOT_WRITE;
    else if (any_req)                slot = SLOT_READ;
    pop  = (slot == SLOT_WRITE);
    // A full FIFO still takes a word when its head leaves this cycle
    push = wr_strobe && ((cnt_q != 2'd2) || pop);
  end

  // Next state for FIFO, starve counter, RAM port and read pipeline
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = wr_address[RAM_ADDR_WIDTH-1:0];
      fifo_data_d[wr_ptr_q] = wr_data;
    end
    wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = pop  ? ~rd_ptr_q : rd_ptr_q;
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
    overflow_d = overflow_q | (wr_strobe & ~push);

    starve_d = '0;
    if (any_req && slot == SLOT_WRITE)
      starve_d = (starve_q == SC_W'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;

    ram_cs_d      = 1'b0;
    ram_wren_d    = 1'b0;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    rd_ack_d      = '0;
    vld_p0_d      = 1'b0;
    idx_p0_d      = idx_p0_q;
    case (slot)
      SLOT_WRITE: begin
        ram_cs_d      = 1'b1;
        ram_wren_d    = 1'b1;
        ram_address_d = fifo_addr_q[rd_ptr_q];
        ram_data_in_d = fifo_data_q[rd_ptr_q];
      end
      SLOT_READ: begin
        ram_cs_d      = 1'b1;
        ram_address_d = rd_addr_arr[grant_index];
        rd_ack_d      = grant;
        vld_p0_d      = 1'b1;
        idx_p0_d      = grant_index;
      end
      default: ;
    endcase

    // Reader index rides along while the SPRAM performs its read
    vld_p1_d   = vld_p0_q;
    idx_p1_d   = idx_p0_q;
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    if (vld_p1_q) begin
      rd_valid_d[idx_p1_q] = 1'b1;
      rd_data_d            = ram_data_out;
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  // Control and output registers; reset drops queued writes and reads in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      starve_q      <= '0;
      overflow_q    <= 1'b0;
      ram_cs_q      <= 1'b0;
      ram_wren_q    <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      rd_ack_q      <= '0;
      vld_p0_q      <= 1'b0;
      idx_p0_q      <= '0;
      vld_p1_q      <= 1'b0;
      idx_p1_q      <= '0;
      rd_valid_q    <= '0;
      rd_data_q     <= '0;
    end else begin
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      starve_q      <= starve_d;
      overflow_q    <= overflow_d;
      // stage p0: slot issued to the RAM port
      ram_cs_q      <= ram_cs_d;
      ram_wren_q    <= ram_wren_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
      rd_ack_q      <= rd_ack_d;
      vld_p0_q      <= vld_p0_d;
      idx_p0_q      <= idx_p0_d;
      // stage p1: SPRAM captures the read address
      vld_p1_q      <= vld_p1_d;
      idx_p1_q      <= idx_p1_d;
      // stage p2: read data returned to the winning reader
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign wr_overflow = overflow_q;
  assign rd_ack      = rd_ack_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;
  assign ram_wren    = ram_wren_q;
  assign ram_cs      = ram_cs_q;

endmodule

// File: tb/tb_word_ram_arbiter.sv
// Bench for word_ram_arbiter: behavioural SPRAM, reference memory and a
// read scoreboard (expected word + due cycle queued at each grant).
module tb_word_ram_arbiter;

  localparam int AW = 14;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [15:0]       wr_data = '0;
  logic [AW-1:0]     wr_address = '0;
  logic              wr_strobe = 1'b0;
  logic              wr_overflow;
  logic [NR-1:0]     rd_req = '0;
  logic [NR*AW-1:0]  rd_address = '0;
  logic [NR-1:0]     rd_ack, rd_valid;
  logic [15:0]       rd_data;
  logic [13:0]       ram_address;
  logic [15:0]       ram_data_in;
  logic              ram_wren, ram_cs;
  logic [15:0]       ram_data_out;

  always #5 clk = ~clk;

  word_ram_arbiter #(.ADDRESS_BUS_WIDTH(13), .READERS(NR), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_address(wr_address), .wr_strobe(wr_strobe),
    .wr_overflow(wr_overflow),
    .rd_req(rd_req), .rd_address(rd_address), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_wren(ram_wren), .ram_cs(ram_cs), .ram_data_out(ram_data_out)
  );

  // Behavioural SPRAM: one-cycle registered read, write on WREN
  logic [15:0] mem [0:16383];
  logic [15:0] ram_q = '0;
  always @(posedge clk) begin
    if (ram_cs && ram_wren)  mem[ram_address] <= ram_data_in;
    if (ram_cs && !ram_wren) ram_q <= mem[ram_address];
  end
  assign ram_data_out = ram_q;

  logic [15:0] ref_mem [0:16383];

  typedef struct { int idx; logic [15:0] data; int due; } sb_t;
  sb_t sb[$];
  int  ack_log[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_wren_cyc = 0, last_ack_cyc = 0;
  int wr_run = 0, max_wr_run = 0;
  logic [13:0] last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_overflow"}, wr_overflow, 0);
    check_val({pfx, "_rd_ack"},   rd_ack, 0);
    check_val({pfx, "_rd_valid"}, rd_valid, 0);
    check_val({pfx, "_rd_data"},  rd_data, 0);
    check_val({pfx, "_ram_addr"}, ram_address, 0);
    check_val({pfx, "_ram_din"},  ram_data_in, 0);
    check_val({pfx, "_ram_wren"}, ram_wren, 0);
    check_val({pfx, "_ram_cs"},   ram_cs, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_strobe = 1'b0;
    rd_req = '0;
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_word(input logic [13:0] a, input logic [15:0] d);
    wr_address = a;
    wr_data = d;
    wr_strobe = 1'b1;
    ref_mem[a] = d;
    tick();
    wr_strobe = 1'b0;
  endtask

  // Request and drop rd_req in the ack cycle, as an output engine would
  task automatic read_word(input int r, input logic [13:0] a);
    rd_address[r*AW +: AW] = a;
    rd_req[r] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rd_ack[r]) begin
        rd_req[r] = 1'b0;
        return;
      end
    end
    rd_req[r] = 1'b0;
    check_val("ack_timeout", 0, 1);
  endtask

  // Monitor: sample away from the active edge, score grants and returns
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (ram_wren) begin
          last_wren_cyc = cyc;
          last_wr_addr = ram_address;
          last_wr_data = ram_data_in;
          wr_run++;
          if (wr_run > max_wr_run) max_wr_run = wr_run;
        end else begin
          wr_run = 0;
        end
        if (rd_ack != '0) begin
          sb_t e;
          check_val("ack_onehot", $countones(rd_ack), 1);
          e.idx = 0;
          for (int i = 0; i < NR; i++) if (rd_ack[i]) e.idx = i;
          e.data = ref_mem[rd_address[e.idx*AW +: AW]];
          e.due = cyc + 2;
          sb.push_back(e);
          ack_log.push_back(e.idx);
          last_ack_cyc = cyc;
        end
        if (rd_valid != '0) begin
          if (sb.size() == 0) begin
            check_val("unexpected_valid", rd_valid, 0);
          end else begin
            sb_t e;
            e = sb.pop_front();
            check_val("valid_idx", rd_valid, 32'(1) << e.idx);
            check_val("rd_data", rd_data, e.data);
            check_val("valid_latency", cyc, e.due);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset values
    repeat (2) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single write then read of the same word
    write_word(14'h0030, 16'h1234);
    repeat (3) tick();
    write_word(14'h0010, 16'hBEEF);
    read_word(1, 14'h0010);
    repeat (4) tick();
    check_val("wren_before_ack", last_wren_cyc < last_ack_cyc, 1);
    check_val("wr_addr_pins", last_wr_addr, 14'h0010);
    check_val("wr_data_pins", last_wr_data, 16'hBEEF);
    check_val("sb_drained_1", sb.size(), 0);

    // Round-robin with every reader requesting
    do_reset();
    for (int i = 0; i < NR; i++) write_word(14'(14'h0020 + i), 16'(16'h5A00 + i));
    repeat (3) tick();
    for (int i = 0; i < NR; i++) rd_address[i*AW +: AW] = 14'(14'h0020 + i);
    ack_log.delete();
    rd_req = '1;
    repeat (8) tick();
    rd_req = '0;
    repeat (4) tick();
    check_val("rr_ack_count", ack_log.size(), 8);
    for (int k = 0; k < ack_log.size() && k < 8; k++)
      check_val($sformatf("rr_ack_%0d", k), ack_log[k], k % NR);
    check_val("sb_drained_rr", sb.size(), 0);

    // Starvation guard: reader 2 held against a write on every cycle.
    // The FIFO first meets a guard READ slot while full on the 11th strobe.
    do_reset();
    ack_log.delete();
    max_wr_run = 0;
    rd_address[2*AW +: AW] = 14'h0030;
    rd_req[2] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      wr_address = 14'(14'h0100 + k);
      wr_data = 16'(16'hC000 + k);
      wr_strobe = 1'b1;
      tick();
    end
    wr_strobe = 1'b0;
    check_val("starve_overflow", wr_overflow, 1);
    rd_req[2] = 1'b0;
    repeat (6) tick();
    check_val("starve_max_run", max_wr_run, 4);
    check_val("starve_acks", ack_log.size(), 3);
    check_val("sb_drained_starve", sb.size(), 0);

    // Overflow boundary: strobes into a full FIFO with and without a pop
    do_reset();
    rd_address[0 +: AW] = 14'h0031;
    rd_req[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wr_address = 14'(14'h0200 + k);
      wr_data = 16'(16'hA000 + k);
      wr_strobe = 1'b1;
      tick();
    end
    check_val("ovf_with_pop", wr_overflow, 0);
    wr_address = 14'h020A;
    wr_data = 16'hA00A;
    tick();
    wr_strobe = 1'b0;
    check_val("ovf_no_pop", wr_overflow, 1);
    rd_req[0] = 1'b0;
    repeat (6) tick();
    check_val("full_push_pop_written", mem[14'h0209], 16'hA009);
    check_val("dropped_not_written", mem[14'h020A], 16'h0000);

    // Reset one cycle after a grant: the read must never return
    do_reset();
    read_word(0, 14'h0010);
    tick();
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_outputs_zero("midrst");
    tick();
    check_val("midrst_no_valid", rd_valid, 0);
    rst_n = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < NR; i++) rd_address[i*AW +: AW] = 14'h0010;
    rd_req = '1;
    tick();
    rd_req = '0;
    check_val("first_after_reset", rd_ack, 4'b0001);
    repeat (4) tick();
    check_val("sb_drained_midrst", sb.size(), 0);

    // Withdrawn request while a write holds the slot
    do_reset();
    ack_log.delete();
    write_word(14'h0040, 16'h7777);
    rd_address[3*AW +: AW] = 14'h0040;
    rd_req[3] = 1'b1;
    tick();
    rd_req[3] = 1'b0;
    check_val("withdraw_write_slot", ram_wren, 1);
    repeat (5) tick();
    check_val("withdrawn_no_ack", ack_log.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
